// File: rtl/frame_compositor.sv
// Final pixel stage: priority merge of background, enemy and car layers into a registered colour,
// plus collision detection and the per-frame play/crash/respawn/game-over life controller.
module frame_compositor #(
  parameter int CRASH_FRAMES = 60,
  parameter int BLINK_FRAMES = 90,
  parameter int BLINK_LOG2   = 3,
  parameter int LIVES_INIT   = 3,
  parameter int LIVES_W      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_video_on,
  input  logic               i_frame_tick,
  input  logic               i_restart,
  input  logic [2:0]         i_bg_rgb,
  input  logic               i_car_on,
  input  logic [2:0]         i_car_rgb,
  input  logic               i_enemy_on,
  input  logic [2:0]         i_enemy_rgb,
  output logic [2:0]         o_rgb,
  output logic               o_alive,
  output logic [LIVES_W-1:0] o_lives,
  output logic               o_game_over,
  output logic               o_crash_pulse,
  output logic [1:0]         o_state
);

  localparam int MAX_FRAMES = (CRASH_FRAMES > BLINK_FRAMES) ? CRASH_FRAMES : BLINK_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES) + 1;

  typedef enum logic [1:0] {
    S_PLAY    = 2'd0,
    S_CRASH   = 2'd1,
    S_RESPAWN = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic [CNT_W-1:0]   w_next_cnt;
  logic [LIVES_W-1:0] r_lives;
  logic [LIVES_W-1:0] w_next_lives;
  logic               r_hit_flag;
  logic               w_next_hit;
  logic               w_crash_start;
  logic               r_crash_pulse;
  logic               w_hit;
  logic               w_car_vis;
  logic [2:0]         w_rgb;
  logic [2:0]         r_rgb;

  // Road black and lane-mark yellow are the only safe background colours.
  assign w_hit = i_video_on & i_car_on &
                 (i_enemy_on | ((i_bg_rgb != 3'b000) & (i_bg_rgb != 3'b110)));

  assign w_car_vis = (r_state == S_PLAY) | (r_state == S_CRASH) |
                     ((r_state == S_RESPAWN) & ~r_frame_cnt[BLINK_LOG2]);

  always_comb begin
    w_rgb = i_bg_rgb;
    if (!i_video_on) begin
      w_rgb = 3'b000;
    end else if (w_car_vis && i_car_on) begin
      w_rgb = (r_state == S_CRASH) ? 3'b100 : i_car_rgb;
    end else if (i_enemy_on) begin
      w_rgb = i_enemy_rgb;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_frame_cnt;
    w_next_lives  = r_lives;
    w_crash_start = 1'b0;
    case (r_state)
      S_PLAY: begin
        if (i_frame_tick && r_hit_flag) begin
          w_next_state  = S_CRASH;
          w_next_lives  = r_lives - LIVES_W'(1);
          w_next_cnt    = '0;
          w_crash_start = 1'b1;
        end
      end
      S_CRASH: begin
        if (i_frame_tick) begin
          if (r_frame_cnt == CNT_W'(CRASH_FRAMES - 1)) begin
            w_next_state = (r_lives == '0) ? S_OVER : S_RESPAWN;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_frame_cnt + CNT_W'(1);
          end
        end
      end
      S_RESPAWN: begin
        if (i_frame_tick) begin
          if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
            w_next_state = S_PLAY;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_frame_cnt + CNT_W'(1);
          end
        end
      end
      S_OVER: begin
        if (i_restart) begin
          w_next_state = S_PLAY;
          w_next_lives = LIVES_W'(LIVES_INIT);
          w_next_cnt   = '0;
        end
      end
      default: w_next_state = S_PLAY;
    endcase
  end

  // A hit on the tick cycle itself seeds the next frame's flag.
  always_comb begin
    w_next_hit = r_hit_flag;
    if ((r_state == S_OVER) && i_restart) begin
      w_next_hit = 1'b0;
    end else if (i_frame_tick) begin
      w_next_hit = (r_state == S_PLAY) & w_hit;
    end else if (r_state == S_PLAY) begin
      w_next_hit = r_hit_flag | w_hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_PLAY;
      r_frame_cnt   <= '0;
      r_lives       <= LIVES_W'(LIVES_INIT);
      r_hit_flag    <= 1'b0;
      r_crash_pulse <= 1'b0;
      r_rgb         <= 3'b000;
    end else begin
      r_state       <= w_next_state;
      r_frame_cnt   <= w_next_cnt;
      r_lives       <= w_next_lives;
      r_hit_flag    <= w_next_hit;
      r_crash_pulse <= w_crash_start;
      r_rgb         <= w_rgb;
    end
  end

  assign o_rgb         = r_rgb;
  assign o_alive       = (r_state == S_PLAY) | (r_state == S_RESPAWN);
  assign o_lives       = r_lives;
  assign o_game_over   = (r_state == S_OVER);
  assign o_crash_pulse = r_crash_pulse;
  assign o_state       = r_state;

endmodule

// File: tb/tb_frame_compositor.sv
// Randomized and directed stimulus for frame_compositor, scored against a frame-level
// game model through an expected-response queue.
module tb_frame_compositor;

  localparam int CRASH_FRAMES = 60;
  localparam int BLINK_FRAMES = 90;
  localparam int BLINK_LOG2   = 3;
  localparam int LIVES_INIT   = 3;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_video_on = 1'b0;
  logic       i_frame_tick = 1'b0;
  logic       i_restart = 1'b0;
  logic [2:0] i_bg_rgb = 3'b000;
  logic       i_car_on = 1'b0;
  logic [2:0] i_car_rgb = 3'b000;
  logic       i_enemy_on = 1'b0;
  logic [2:0] i_enemy_rgb = 3'b000;
  logic [2:0] o_rgb;
  logic       o_alive;
  logic [1:0] o_lives;
  logic       o_game_over;
  logic       o_crash_pulse;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  frame_compositor dut (
    .clk(clk), .reset(reset),
    .i_video_on(i_video_on), .i_frame_tick(i_frame_tick), .i_restart(i_restart),
    .i_bg_rgb(i_bg_rgb), .i_car_on(i_car_on), .i_car_rgb(i_car_rgb),
    .i_enemy_on(i_enemy_on), .i_enemy_rgb(i_enemy_rgb),
    .o_rgb(o_rgb), .o_alive(o_alive), .o_lives(o_lives), .o_game_over(o_game_over),
    .o_crash_pulse(o_crash_pulse), .o_state(o_state)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  // Game model: a life controller counting whole frames
  typedef enum {M_PLAY, M_CRASH, M_RESPAWN, M_OVER} mode_t;
  mode_t m_mode;
  int    m_lives;
  int    m_frames;
  bit    m_hit_seen;
  bit    m_pulse;

  function automatic void model_reset();
    m_mode = M_PLAY; m_lives = LIVES_INIT; m_frames = 0; m_hit_seen = 0; m_pulse = 0;
  endfunction

  function automatic logic [7:0] model_step(bit vo, bit tick, bit rst, logic [2:0] bg,
                                            bit con, logic [2:0] crgb, bit eon, logic [2:0] ergb);
    logic [2:0] rgb;
    bit    blink_off, vis, hit, alive, over;
    mode_t prev;
    prev      = m_mode;
    blink_off = (m_mode == M_RESPAWN) && (((m_frames / (1 << BLINK_LOG2)) % 2) == 1);
    vis       = (m_mode != M_OVER) && !blink_off;
    if (!vo) rgb = 3'b000;
    else if (vis && con) rgb = (m_mode == M_CRASH) ? 3'b100 : crgb;
    else if (eon) rgb = ergb;
    else rgb = bg;
    hit = vo && con && (eon || (bg != 3'b000 && bg != 3'b110));
    m_pulse = 0;
    if (m_mode == M_OVER && rst) begin
      m_mode = M_PLAY; m_lives = LIVES_INIT; m_hit_seen = 0; m_frames = 0;
    end else if (tick) begin
      case (prev)
        M_PLAY:
          if (m_hit_seen) begin
            m_mode = M_CRASH; m_lives = m_lives - 1; m_pulse = 1; m_frames = 0;
          end
        M_CRASH:
          if (m_frames == CRASH_FRAMES - 1) begin
            m_mode = (m_lives == 0) ? M_OVER : M_RESPAWN; m_frames = 0;
          end else m_frames = m_frames + 1;
        M_RESPAWN:
          if (m_frames == BLINK_FRAMES - 1) begin
            m_mode = M_PLAY; m_frames = 0;
          end else m_frames = m_frames + 1;
        default: ;
      endcase
      m_hit_seen = (prev == M_PLAY) && hit;
    end else if (m_mode == M_PLAY) begin
      m_hit_seen = m_hit_seen || hit;
    end
    alive = (m_mode == M_PLAY) || (m_mode == M_RESPAWN);
    over  = (m_mode == M_OVER);
    return {rgb, alive, 2'(m_lives), over, m_pulse};
  endfunction

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // driver tasks
  task automatic drive(bit vo, bit tick, bit rst, logic [2:0] bg,
                       bit con, logic [2:0] crgb, bit eon, logic [2:0] ergb);
    @(negedge clk);
    #1;
    i_video_on = vo; i_frame_tick = tick; i_restart = rst; i_bg_rgb = bg;
    i_car_on = con; i_car_rgb = crgb; i_enemy_on = eon; i_enemy_rgb = ergb;
    exp_q.push_back(model_step(vo, tick, rst, bg, con, crgb, eon, ergb));
  endtask

  task automatic safe_pixel(bit tick, bit rst);
    bit con;
    con = ($urandom_range(0, 1) == 1);
    drive($urandom_range(0, 3) != 0, tick, rst, ($urandom_range(0, 1) == 1) ? 3'b110 : 3'b000,
          con, 3'($urandom_range(1, 7)), con ? 1'b0 : 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)));
  endtask

  // One frame of len cycles; optionally one guaranteed off-road pixel.
  task automatic frame(int len, bit with_hit);
    for (int i = 0; i < len - 1; i++) begin
      if (with_hit && i == 0) drive(1, 0, 0, 3'b010, 1, 3'b111, 0, 3'b000);
      else safe_pixel(0, 0);
    end
    safe_pixel(1, 0);
  endtask

  task automatic run_random(int n, int len);
    for (int i = 0; i < n; i++) begin
      drive($urandom_range(0, 3) != 0, (i % len) == len - 1, $urandom_range(0, 63) == 0,
            3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)));
    end
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_rgb"}, o_rgb, 0);
    check({tag, "_alive"}, o_alive, 1);
    check({tag, "_lives"}, o_lives, LIVES_INIT);
    check({tag, "_game_over"}, o_game_over, 0);
    check({tag, "_crash_pulse"}, o_crash_pulse, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  // scoreboard monitor: expectation pushed one cycle earlier is due now
  logic [7:0] mon_exp;
  logic [7:0] mon_act;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {o_rgb, o_alive, o_lives, o_game_over, o_crash_pulse};
      tests++;
      if (mon_act !== mon_exp) begin
        fails++;
        $display("FAIL scoreboard @%0t: got rgb=%b alive=%b lives=%0d over=%b pulse=%b, expected rgb=%b alive=%b lives=%0d over=%b pulse=%b",
                 $time, mon_act[7:5], mon_act[4], mon_act[3:2], mon_act[1], mon_act[0],
                 mon_exp[7:5], mon_exp[4], mon_exp[3:2], mon_exp[1], mon_exp[0]);
      end
    end
  end

  initial begin
    model_reset();
    #23;
    check_reset_values("reset");
    @(negedge clk);
    #2 reset = 1'b0;

    // car over road: colour passes, no hit
    drive(1, 0, 0, 3'b000, 1, 3'b111, 0, 3'b000);
    drive(1, 0, 0, 3'b000, 1, 3'b111, 0, 3'b000);
    drive(0, 1, 0, 3'b000, 0, 3'b000, 0, 3'b000);
    drive(0, 0, 0, 3'b000, 0, 3'b000, 0, 3'b000);

    // blanked overlap is harmless; visible overlap on lane mark crashes
    drive(0, 0, 0, 3'b110, 1, 3'b101, 1, 3'b011);
    drive(0, 1, 0, 3'b000, 0, 3'b000, 0, 3'b000);
    drive(0, 0, 0, 3'b000, 0, 3'b000, 0, 3'b000);
    drive(1, 0, 0, 3'b110, 1, 3'b101, 1, 3'b011);
    drive(0, 1, 0, 3'b000, 0, 3'b000, 0, 3'b000);
    drive(1, 0, 0, 3'b000, 1, 3'b111, 0, 3'b000);
    drive(1, 0, 0, 3'b000, 0, 3'b111, 1, 3'b001);

    // crash period, then blinking respawn with ignored hits
    for (int f = 0; f < CRASH_FRAMES + BLINK_FRAMES + 2; f++) frame(4, f >= CRASH_FRAMES);
    for (int f = 0; f < 3; f++) frame(4, 0);

    // hit on the tick cycle itself defers the crash by one frame
    drive(1, 1, 0, 3'b010, 1, 3'b111, 0, 3'b000);
    drive(0, 0, 0, 3'b000, 0, 3'b000, 0, 3'b000);
    drive(0, 1, 0, 3'b000, 0, 3'b000, 0, 3'b000);
    drive(0, 0, 0, 3'b000, 0, 3'b000, 0, 3'b000);

    // burn through remaining lives into game over, car hidden there
    for (int f = 0; f < 2 * (CRASH_FRAMES + BLINK_FRAMES) + 10; f++) frame(4, 1);
    for (int i = 0; i < 5; i++) safe_pixel(0, 0);
    drive(0, 0, 1, 3'b000, 0, 3'b000, 0, 3'b000);
    drive(1, 0, 0, 3'b000, 1, 3'b110, 0, 3'b000);

    // asynchronous reset while crashing
    frame(4, 1);
    frame(4, 1);
    for (int f = 0; f < 5; f++) frame(4, 0);
    async_reset();
    drive(1, 0, 0, 3'b000, 1, 3'b011, 0, 3'b000);

    run_random(3000, 4);
    async_reset();
    run_random(3000, 3);
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
